cabac_bin_sequencer: RTL

Hardware replacement for the software bin-count loop around `Decoder`. It accepts decode commands `{pState, bypass, numBins}` over a valid/ready handshake and drives `Decoder` with a per-cycle step strobe and `n_bin`. It collects the decoded bins into a one-entry output register with a valid/ready handshake and marks the last group of each command. The block sits between the syntax-element parser (command source) and `Decoder`; `FileReader`/byte refill stays inside the decoder path and is seen here only as `dec_stall`.

---
 rtl/cabac_bin_sequencer_if.sv | 40 ++++
 rtl/cabac_bin_sequencer.sv | 109 ++++++++++
 2 files changed

// File: rtl/cabac_bin_sequencer_if.sv
// Command, decoder-step and bin-group signals of the CABAC bin sequencer.
// slave = sequencer view, master = command source / decoder / consumer view.
interface cabac_bin_sequencer_if #(
    parameter int BIN_WIDTH = 3,
    parameter int NB_WIDTH  = 7
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [7:0]           cmd_pstate;
    logic                 cmd_bypass;
    logic [NB_WIDTH-1:0]  cmd_num_bins;

    logic                 dec_en;
    logic [7:0]           dec_pstate;
    logic                 dec_bypass;
    logic [1:0]           dec_n_bin;
    logic                 dec_stall;
    logic [BIN_WIDTH-1:0] dec_bin;

    logic                 out_valid;
    logic                 out_ready;
    logic [BIN_WIDTH-1:0] out_bins;
    logic [1:0]           out_cnt;
    logic                 out_last;
    logic                 busy;

    modport slave (
        input  cmd_valid, cmd_pstate, cmd_bypass, cmd_num_bins,
        input  dec_stall, dec_bin, out_ready,
        output cmd_ready, dec_en, dec_pstate, dec_bypass, dec_n_bin,
        output out_valid, out_bins, out_cnt, out_last, busy
    );

    modport master (
        output cmd_valid, cmd_pstate, cmd_bypass, cmd_num_bins,
        output dec_stall, dec_bin, out_ready,
        input  cmd_ready, dec_en, dec_pstate, dec_bypass, dec_n_bin,
        input  out_valid, out_bins, out_cnt, out_last, busy
    );
endinterface

// File: rtl/cabac_bin_sequencer.sv
// Splits {pstate, bypass, num_bins} commands into decoder steps and registers each bin group.
// First group visible one edge after acceptance; dec_en drops on dec_stall or a full, undrained output slot.
module cabac_bin_sequencer #(
    parameter int BIN_WIDTH = 3,
    parameter int NB_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    cabac_bin_sequencer_if.slave  bus
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_q, state_d;
    logic [NB_WIDTH-1:0]  rem_q, rem_d;
    logic [NB_WIDTH-1:0]  step;
    logic [BIN_WIDTH-1:0] step_mask;
    logic [7:0]           pstate_q;
    logic                 bypass_q;
    logic                 out_valid_q;
    logic [BIN_WIDTH-1:0] out_bins_q;
    logic [1:0]           out_cnt_q;
    logic                 out_last_q;
    logic                 slot_free;
    logic                 step_en;
    logic                 start;

    // Bypass steps take as many bins as remain, capped at BIN_WIDTH; regular steps are single bins.
    always_comb begin
        step      = NB_WIDTH'(1);
        step_mask = '0;
        if (bypass_q) begin
            if (rem_q > NB_WIDTH'(BIN_WIDTH)) step = NB_WIDTH'(BIN_WIDTH);
            else                              step = rem_q;
        end
        for (int i = 0; i < BIN_WIDTH; i++) begin
            step_mask[i] = (NB_WIDTH'(i) < step);
        end
    end

    assign slot_free = !out_valid_q || bus.out_ready;
    assign step_en   = (state_q == RUN) && !bus.dec_stall && slot_free;
    assign start     = (state_q == IDLE) && bus.cmd_valid && (bus.cmd_num_bins != '0);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    rem_d   = bus.cmd_num_bins;
                end
            end
            RUN: begin
                if (step_en) begin
                    rem_d = rem_q - step;
                    if (rem_q == step) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            pstate_q <= '0;
            bypass_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            if (start) begin
                pstate_q <= bus.cmd_pstate;
                bypass_q <= bus.cmd_bypass;
            end
        end
    end

    // A load in the same cycle as a drain keeps the slot full, giving one group per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_bins_q  <= '0;
            out_cnt_q   <= '0;
            out_last_q  <= 1'b0;
        end else if (step_en) begin
            out_valid_q <= 1'b1;
            out_bins_q  <= bus.dec_bin & step_mask;
            out_cnt_q   <= 2'(step - NB_WIDTH'(1));
            out_last_q  <= (rem_q == step);
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.cmd_ready  = (state_q == IDLE);
    assign bus.busy       = (state_q == RUN);
    assign bus.dec_en     = step_en;
    assign bus.dec_pstate = pstate_q;
    assign bus.dec_bypass = bypass_q;
    assign bus.dec_n_bin  = (state_q == RUN) ? 2'(step - NB_WIDTH'(1)) : 2'b0;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_bins   = out_bins_q;
    assign bus.out_cnt    = out_cnt_q;
    assign bus.out_last   = out_last_q;

endmodule
